// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Op encodings, geometry and FSM states live here.
package dmem_pkg;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    localparam logic [31:0] ADDR_LIMIT = 32'd512;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SWAP  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    function automatic logic req_bad(logic [1:0] op, logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT) || (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between an initiator and the responder.
// Both channels use a valid/ready handshake.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// 128 x 32 word store, one sync read port and one write port.
// Reads on a write edge return the pre-write contents.
module dmem_array
    import dmem_pkg::*;
(
    input  logic          clk,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i
);

    logic [31:0] words [DEPTH];
    logic [31:0] rdata_q;

    // Each word powers up holding its own index; reset never touches it.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [31:0] word_q = 32'(i);

        always_ff @(posedge clk) begin
            if (we_i && (waddr_i == AW'(i))) begin
                word_q <= wdata_i;
            end
        end

        assign words[i] = word_q;
    end

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= words[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Three-state memory responder: IDLE accepts, ACCESS touches the
// array, RESP holds the result until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    state_e      state_q, state_d;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q, err_d;
    logic        rsel_q, rsel_d;
    logic        accept;
    logic        bad;
    logic        re;
    logic        we;
    logic [31:0] arr_rdata;

    assign accept = bus.req_valid && (state_q == ST_IDLE);
    assign bad    = req_bad(op_q, addr_q);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rsel_d  = rsel_q;
        re      = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                err_d   = bad;
                rsel_d  = !bad && ((op_q == OP_READ) || (op_q == OP_SWAP));
                re      = rsel_d;
                // A reset landing on this edge must not commit the store.
                we      = rst && !bad && ((op_q == OP_WRITE) || (op_q == OP_SWAP));
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                    rsel_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rsel_q  <= rsel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    dmem_array u_array (
        .clk     (clk),
        .re_i    (re),
        .raddr_i (addr_q[8:2]),
        .rdata_o (arr_rdata),
        .we_i    (we),
        .waddr_i (addr_q[8:2]),
        .wdata_i (wdata_q)
    );

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rsel_q ? arr_rdata : 32'd0;
    assign bus.resp_err   = err_q;

endmodule
